// File: rtl/if_icache.sv
// Direct-mapped, one-word-per-line instruction cache with zero-latency hits and a blocking refill.
// Define IF_ICACHE_STATS_EN to add the hit_count / miss_count statistics outputs.
module if_icache #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 8,
    parameter int INST_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    input  logic              flush,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_valid,
    output logic              stall_flag,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
`ifdef IF_ICACHE_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_data
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic {S_IDLE, S_REFILL} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [INST_W-1:0]   r_data [LINES];
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_kill;

    logic [INDEX_W-1:0]  w_index;
    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_fill_index;
    logic [TAG_W-1:0]    w_fill_tag;
    logic                w_hit;
    logic                w_miss;
    logic                w_fill;

    assign w_index      = pc[INDEX_W+1:2];
    assign w_tag        = pc[ADDR_W-1:INDEX_W+2];
    assign w_fill_index = r_mem_addr[INDEX_W+1:2];
    assign w_fill_tag   = r_mem_addr[ADDR_W-1:INDEX_W+2];

    assign w_hit  = pc_valid & r_valid[w_index] & (r_tag[w_index] == w_tag)
                  & (r_state == S_IDLE) & ~flush;
    assign w_miss = pc_valid & ~w_hit & ~flush & (r_state == S_IDLE);
    // A flush in the ack cycle, or one seen earlier in this refill, drops the returning word.
    assign w_fill = (r_state == S_REFILL) & mem_ack & ~r_kill & ~flush;

    // NOTE: every output gets a default before any branch so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        out_valid   = w_hit;
        out_pc      = '0;
        out_inst    = '0;
        stall_flag  = pc_valid & ~w_hit & ~rst;
        mem_req     = (r_state == S_REFILL);
        mem_addr    = r_mem_addr;
        if (w_hit) begin
            out_pc   = pc;
            out_inst = r_data[w_index];
        end
        if (r_state == S_IDLE) begin
            if (w_miss) w_state_nxt = S_REFILL;
        end else if (mem_ack) begin
            w_state_nxt = S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mem_addr <= '0;
            r_kill     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_miss) r_mem_addr <= {pc[ADDR_W-1:2], 2'b00};
            if (r_state == S_REFILL && !mem_ack && flush) r_kill <= 1'b1;
            else if (w_state_nxt == S_IDLE)               r_kill <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_valid <= '0;
        else if (flush)  r_valid <= '0;
        else if (w_fill) r_valid[w_fill_index] <= 1'b1;
    end

    // NOTE: tag/data storage has no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= mem_data;
        end
    end

`ifdef IF_ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_hit)  r_hit_count  <= r_hit_count + 32'd1;
            if (w_miss) r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_if_icache.sv
// Self-checking bench for if_icache: directed scenarios plus randomized traffic against a line-address cache model.
// Honours IF_ICACHE_STATS_EN when the design is built with the statistics counters.
module tb_if_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_valid;
    logic        stall_flag;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
`ifdef IF_ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    if_icache dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .flush(flush),
        .out_pc(out_pc), .out_inst(out_inst), .out_valid(out_valid), .stall_flag(stall_flag),
        .mem_req(mem_req), .mem_addr(mem_addr),
`ifdef IF_ICACHE_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .mem_ack(mem_ack), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: each index remembers which word address it holds; one outstanding refill at most.
    bit          m_valid [256];
    logic [29:0] m_word  [256];
    logic [31:0] m_data  [256];
    bit          m_busy;
    bit          m_kill;
    logic [31:0] m_addr;
    int unsigned m_hits;
    int unsigned m_misses;

    logic        obs_valid, obs_stall, obs_req;
    logic [31:0] obs_inst, obs_addr;

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_busy   = 1'b0;
        m_kill   = 1'b0;
        m_addr   = '0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // One clock: apply inputs, compare at the falling edge, advance the model at the rising edge.
    task automatic step(input logic [31:0] a_pc, input logic a_v, input logic a_fl,
                        input logic a_ack, input logic [31:0] a_data);
        int  idx;
        bit  e_hit;
        pc = a_pc; pc_valid = a_v; flush = a_fl; mem_ack = a_ack; mem_data = a_data;
        @(negedge clk);
        idx   = int'(a_pc[9:2]);
        e_hit = a_v && !m_busy && !a_fl && m_valid[idx] && (m_word[idx] == a_pc[31:2]);
        check("out_valid", out_valid, e_hit);
        check("out_pc", out_pc, e_hit ? a_pc : 32'h0);
        check("out_inst", out_inst, e_hit ? m_data[idx] : 32'h0);
        check("stall_flag", stall_flag, a_v && !e_hit);
        check("mem_req", mem_req, m_busy);
        check("mem_addr", mem_addr, m_addr);
`ifdef IF_ICACHE_STATS_EN
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
`endif
        obs_valid = out_valid; obs_stall = stall_flag; obs_req = mem_req;
        obs_inst  = out_inst;  obs_addr  = mem_addr;
        @(posedge clk);
        if (m_busy) begin
            if (a_ack) begin
                if (!m_kill && !a_fl) begin
                    m_valid[int'(m_addr[9:2])] = 1'b1;
                    m_word[int'(m_addr[9:2])]  = m_addr[31:2];
                    m_data[int'(m_addr[9:2])]  = a_data;
                end
                m_busy = 1'b0;
                m_kill = 1'b0;
            end else if (a_fl) begin
                m_kill = 1'b1;
            end
        end else if (a_v && !e_hit && !a_fl) begin
            m_busy = 1'b1;
            m_addr = {a_pc[31:2], 2'b00};
            m_misses++;
        end
        if (a_fl) foreach (m_valid[i]) m_valid[i] = 1'b0;
        if (e_hit) m_hits++;
        #1;
    endtask

    task automatic refill(input logic [31:0] a_pc, input logic [31:0] a_data, input int n_wait);
        step(a_pc, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (n_wait) step(a_pc, 1'b1, 1'b0, 1'b0, 32'h0);
        step(a_pc, 1'b1, 1'b0, 1'b1, a_data);
    endtask

    initial begin
        logic [31:0] r_pc;
        rst = 1'b1; pc = 32'h10; pc_valid = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_data = '0;
        model_reset();
        #3;
        check("rst out_valid", out_valid, 1'b0);
        check("rst stall_flag", stall_flag, 1'b0);
        check("rst mem_req", mem_req, 1'b0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst out_inst", out_inst, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        pc_valid = 1'b0;
        rst = 1'b0;

        // Cold miss: ack at cycle 4, hit at cycle 5.
        step(32'h10, 1'b1, 1'b0, 1'b0, 32'h0);
        check("cold miss stall", obs_stall, 1'b1);
        step(32'h10, 1'b1, 1'b0, 1'b0, 32'h0);
        check("cold mem_req c1", obs_req, 1'b1);
        check("cold mem_addr c1", obs_addr, 32'h10);
        step(32'h10, 1'b1, 1'b0, 1'b0, 32'h0);
        step(32'h10, 1'b1, 1'b0, 1'b0, 32'h0);
        step(32'h10, 1'b1, 1'b0, 1'b1, 32'h00500093);
        step(32'h10, 1'b1, 1'b0, 1'b0, 32'h0);
        check("cold hit valid", obs_valid, 1'b1);
        check("cold hit inst", obs_inst, 32'h00500093);
        check("cold hit stall", obs_stall, 1'b0);

        // Conflict eviction at index 4.
        refill(32'h410, 32'hAAAA0410, 1);
        step(32'h410, 1'b1, 1'b0, 1'b0, 32'h0);
        check("evict new hit", obs_inst, 32'hAAAA0410);
        step(32'h010, 1'b1, 1'b0, 1'b0, 32'h0);
        check("evict old miss", obs_stall, 1'b1);
        step(32'h010, 1'b1, 1'b0, 1'b1, 32'h00500093);

        // Flush: pulse while cached, then flush coincident with ack.
        step(32'h10, 1'b1, 1'b0, 1'b0, 32'h0);
        check("pre-flush hit", obs_valid, 1'b1);
        step(32'h10, 1'b0, 1'b1, 1'b0, 32'h0);
        step(32'h10, 1'b1, 1'b0, 1'b0, 32'h0);
        check("post-flush miss", obs_stall, 1'b1);
        step(32'h10, 1'b1, 1'b1, 1'b1, 32'h11111111);
        step(32'h10, 1'b1, 1'b0, 1'b0, 32'h0);
        check("flush+ack miss", obs_stall, 1'b1);
        step(32'h10, 1'b1, 1'b0, 1'b1, 32'h22222222);

        // PC redirect mid-refill.
        step(32'h20, 1'b1, 1'b0, 1'b0, 32'h0);
        step(32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
        check("redirect addr hold", obs_addr, 32'h20);
        step(32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
        step(32'h40, 1'b1, 1'b0, 1'b1, 32'h20202020);
        step(32'h40, 1'b1, 1'b0, 1'b0, 32'h0);
        check("redirect new miss", obs_stall, 1'b1);
        step(32'h40, 1'b1, 1'b0, 1'b1, 32'h40404040);
        step(32'h20, 1'b1, 1'b0, 1'b0, 32'h0);
        check("redirect old cached", obs_inst, 32'h20202020);

        // Async reset between edges during a refill.
        step(32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
        step(32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
        #2 rst = 1'b1;
        #1;
        check("async rst mem_req", mem_req, 1'b0);
        check("async rst mem_addr", mem_addr, 32'h0);
        model_reset();
        pc_valid = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        step(32'h80, 1'b0, 1'b0, 1'b0, 32'h0);
        step(32'h80, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        step(32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
        check("stray ack ignored", obs_stall, 1'b1);
        step(32'h80, 1'b1, 1'b0, 1'b1, 32'h80808080);
        repeat (3) step(32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
        check("post-rst refill hit", obs_inst, 32'h80808080);
`ifdef IF_ICACHE_STATS_EN
        check("stats miss_count", miss_count, 32'd1);
        check("stats hit_count", hit_count, 32'd3);
`endif

        // Randomized traffic over a small address set to mix hits, conflicts, flushes and stray acks.
        r_pc = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            logic a_ack;
            if ($urandom_range(2) == 0)
                r_pc = ($urandom_range(3) << 10) | ($urandom_range(7) << 2) | $urandom_range(3);
            a_ack = m_busy ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
            step(r_pc, $urandom_range(7) != 0, $urandom_range(29) == 0, a_ack, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_icache.md
IF_ICACHE -- requirements
Module: if_icache

Interface
REQ-001 Parameter ADDR_W, default 32, instruction address width in bits.
REQ-002 Parameter INDEX_W, default 8, cache index width; the cache holds 2**INDEX_W one-word lines.
REQ-003 Parameter INST_W, default 32, instruction word width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 pc  in  ADDR_W  fetch address from the PC register.
REQ-007 pc_valid  in  1  fetch request qualifier.
REQ-008 flush  in  1  invalidate the whole cache (fence.i / self-modifying code).
REQ-009 out_pc  out  ADDR_W  fetched PC to IF/ID.
REQ-010 out_inst  out  INST_W  fetched instruction to IF/ID.
REQ-011 out_valid  out  1  out_pc/out_inst valid this cycle.
REQ-012 stall_flag  out  1  fetch stall request to the stall bus.
REQ-013 mem_req  out  1  instruction read request to the memory controller.
REQ-014 mem_addr  out  ADDR_W  word-aligned read address, with bits [1:0] = 0.
REQ-015 mem_ack  in  1  read data valid from the memory controller.
REQ-016 mem_data  in  INST_W  returned instruction word.

Function
REQ-017 Direct-mapped; index = pc[INDEX_W+1:2], tag = pc[ADDR_W-1:INDEX_W+2]; pc[1:0] are ignored.
REQ-018 Each line stores a valid bit, a tag and one instruction.
REQ-019 Hit = pc_valid & valid[index] & (tag match) & state==IDLE & !flush.
REQ-020 Hit is combinational and zero-latency: out_valid=1, out_pc=pc, out_inst=line data, stall_flag=0, all in the same cycle.
REQ-021 On a non-hit: out_valid=0, out_pc=0, out_inst=0.
REQ-022 stall_flag=1 whenever pc_valid=1 and there is no hit.
REQ-023 If pc_valid=0: stall_flag=0 and out_valid=0.
REQ-024 FSM has two states, IDLE and REFILL.
REQ-025 IDLE -> REFILL at the edge following a miss (pc_valid & no hit & !flush), latching the miss address as {pc[ADDR_W-1:2],2'b00} into mem_addr.
REQ-026 In REFILL, mem_req=1 and mem_addr is held stable until the cycle in which mem_ack=1.
REQ-027 In the mem_ack cycle, the line at the latched index is written (valid=1, tag, mem_data) at that edge, unless it is suppressed per REQ-030; the FSM returns to IDLE.
REQ-028 Miss latency: miss detected at cycle 0; mem_req asserted from cycle 1; ack at cycle k; a same-pc hit occurs at cycle k+1.
REQ-029 A pc change during REFILL does not abort the refill; the new pc is looked up after the return to IDLE.
REQ-030 flush clears all valid bits at the next edge. A flush during REFILL sets a kill flag; the line write at mem_ack is then suppressed and the FSM still returns to IDLE.
REQ-031 When flush and mem_ack occur in the same cycle, the flush wins and no line is written.
REQ-032 mem_ack while in IDLE is ignored.
REQ-033 mem_req is driven from the state register (registered), never combinationally from pc.

Reset
REQ-034 While rst=1: all valid bits=0, state=IDLE, kill flag=0, mem_req=0, mem_addr=0, out_valid=0, out_pc=0, out_inst=0, stall_flag=0.
REQ-035 rst asserted during REFILL abandons the request immediately; a later stray mem_ack is ignored per REQ-032.
REQ-036 Tag and data arrays need no reset; only the valid bits are reset.

Configuration
REQ-037 Macro IF_ICACHE_STATS_EN defined: adds outputs hit_count and miss_count, each 32 bits, reset to 0.
REQ-038 With IF_ICACHE_STATS_EN, hit_count increments on each hit cycle and miss_count on each IDLE->REFILL transition; both wrap modulo 2**32 and are not cleared by flush.
REQ-039 IF_ICACHE_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

Verification
REQ-040 Cold miss: after reset, pc=0x00000010 with pc_valid=1 -> stall_flag=1; mem_req=1 and mem_addr=0x10 from cycle 1; mem_ack with mem_data=0x00500093 at cycle 4 -> cycle 5 gives out_valid=1, out_inst=0x00500093, stall_flag=0.
REQ-041 Conflict eviction (INDEX_W=8): fill pc=0x010, then pc=0x410 -> miss and refill. Re-access pc=0x010 -> miss again.
REQ-042 Flush: with 0x10 cached, pulse flush for 1 cycle -> the next access to 0x10 misses. Flush asserted in the mem_ack cycle -> no line is written and the next access misses.
REQ-043 PC redirect mid-refill: miss at 0x20, pc changes to 0x40 before ack -> mem_addr stays 0x20 until ack; then 0x40 misses and 0x20 is cached.
REQ-044 Async reset mid-REFILL: rst pulsed between clock edges -> mem_req=0 immediately; a stray mem_ack 2 cycles later has no effect.
REQ-045 With IF_ICACHE_STATS_EN: 1 miss followed by 3 hits -> miss_count=1, hit_count=3.
